// File: rtl/health_tracker.sv
// Two-player health/round controller: saturating damage, post-hit invulnerability, KO/draw detection, match end.
// Registered outputs; one-cycle latency from an accepted hit to the victim's health and round result.
module health_tracker #(
    parameter int MAX_HP        = 10,
    parameter int HP_W          = 4,
    parameter int DMG_W         = 3,
    parameter int INVULN_FRAMES = 30,
    parameter int ROUNDS_TO_WIN = 2,
    localparam int WIN_W        = $clog2(ROUNDS_TO_WIN + 1),
    localparam int IF_W         = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             round_start,
    input  logic             hit1_lands,
    input  logic             hit2_lands,
    input  logic [DMG_W-1:0] dmg1,
    input  logic [DMG_W-1:0] dmg2,
    output logic [HP_W-1:0]  health1,
    output logic [HP_W-1:0]  health2,
    output logic             invuln1,
    output logic             invuln2,
    output logic             fighting,
    output logic             round_over,
    output logic [1:0]       winner,
    output logic [WIN_W-1:0] wins1,
    output logic [WIN_W-1:0] wins2,
    output logic             match_over
);

    localparam int CW = (HP_W > DMG_W) ? HP_W : DMG_W;
    localparam logic [HP_W-1:0]  HP_FULL   = HP_W'(MAX_HP);
    localparam logic [IF_W-1:0]  IF_LOAD   = IF_W'(INVULN_FRAMES);
    localparam logic [WIN_W-1:0] WINS_GOAL = WIN_W'(ROUNDS_TO_WIN);

    typedef enum logic [1:0] {IDLE, FIGHT, KO_HOLD, MATCH_END} state_t;

    state_t           state, state_nxt;
    logic [IF_W-1:0]  cnt1, cnt2;
    logic [HP_W-1:0]  health1_nxt, health2_nxt;
    logic [WIN_W-1:0] wins1_nxt, wins2_nxt;
    logic             hit_on_p1, hit_on_p2;
    logic             ko1, ko2, ko_any, match_win, start_round;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] h,
                                                input logic [DMG_W-1:0] d);
        logic [CW-1:0] hx, dx;
        hx = CW'(h);
        dx = CW'(d);
        return (hx > dx) ? HP_W'(hx - dx) : '0;
    endfunction

    // Damage and KO are resolved on next-state health so the result lands on the same edge.
    always_comb begin
        hit_on_p1   = (state == FIGHT) && hit2_lands && (cnt1 == '0);
        hit_on_p2   = (state == FIGHT) && hit1_lands && (cnt2 == '0);
        health1_nxt = hit_on_p1 ? sat_sub(health1, dmg2) : health1;
        health2_nxt = hit_on_p2 ? sat_sub(health2, dmg1) : health2;
        ko1         = (state == FIGHT) && (health1_nxt == '0);
        ko2         = (state == FIGHT) && (health2_nxt == '0);
        ko_any      = ko1 || ko2;
        wins1_nxt   = (ko2 && !ko1 && wins1 != WINS_GOAL) ? wins1 + WIN_W'(1) : wins1;
        wins2_nxt   = (ko1 && !ko2 && wins2 != WINS_GOAL) ? wins2 + WIN_W'(1) : wins2;
        match_win   = ko_any && ((wins1_nxt == WINS_GOAL) || (wins2_nxt == WINS_GOAL));
        start_round = round_start && ((state == IDLE) || (state == KO_HOLD));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_round) state_nxt = FIGHT;
            FIGHT:     if (ko_any) state_nxt = match_win ? MATCH_END : KO_HOLD;
            KO_HOLD:   if (start_round) state_nxt = FIGHT;
            MATCH_END: state_nxt = MATCH_END;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fighting   = (state == FIGHT);
        round_over = (state == KO_HOLD);
        match_over = (state == MATCH_END);
        invuln1    = (cnt1 != '0);
        invuln2    = (cnt2 != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            health1 <= HP_FULL;
            health2 <= HP_FULL;
            cnt1    <= '0;
            cnt2    <= '0;
            winner  <= 2'b00;
            wins1   <= '0;
            wins2   <= '0;
        end else if (start_round) begin
            health1 <= HP_FULL;
            health2 <= HP_FULL;
            cnt1    <= '0;
            cnt2    <= '0;
            winner  <= 2'b00;
        end else begin
            health1 <= health1_nxt;
            health2 <= health2_nxt;
            if (hit_on_p1)                 cnt1 <= IF_LOAD;
            else if (tick && cnt1 != '0)   cnt1 <= cnt1 - IF_W'(1);
            if (hit_on_p2)                 cnt2 <= IF_LOAD;
            else if (tick && cnt2 != '0)   cnt2 <= cnt2 - IF_W'(1);
            // Bit 1 flags P1 down, bit 0 flags P2 down, so both down reads as a draw.
            if (ko_any) winner <= {ko1, ko2};
            wins1 <= wins1_nxt;
            wins2 <= wins2_nxt;
        end
    end

endmodule

// File: tb/tb_health_tracker.sv
// Directed scenarios for health_tracker; expected output snapshots go to a queue checked at the falling edge.
module tb_health_tracker;

    logic       clk = 1'b0;
    logic       reset, tick, round_start, hit1_lands, hit2_lands;
    logic [2:0] dmg1, dmg2;
    logic [3:0] health1, health2;
    logic       invuln1, invuln2, fighting, round_over, match_over;
    logic [1:0] winner, wins1, wins2;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h2;
        logic       i1;
        logic       i2;
        logic       f;
        logic       ro;
        logic [1:0] w;
        logic [1:0] w1;
        logic [1:0] w2;
        logic       mo;
    } out_t;

    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passes = 0;

    always #5 clk = ~clk;

    health_tracker dut (
        .clk(clk), .reset(reset), .tick(tick), .round_start(round_start),
        .hit1_lands(hit1_lands), .hit2_lands(hit2_lands), .dmg1(dmg1), .dmg2(dmg2),
        .health1(health1), .health2(health2), .invuln1(invuln1), .invuln2(invuln2),
        .fighting(fighting), .round_over(round_over), .winner(winner),
        .wins1(wins1), .wins2(wins2), .match_over(match_over)
    );

    function automatic out_t mk(input int h1, input int h2, input bit i1, input bit i2,
                                input bit f, input bit ro, input int w, input int w1,
                                input int w2, input bit mo);
        out_t o;
        o.h1 = 4'(h1); o.h2 = 4'(h2); o.i1 = i1; o.i2 = i2; o.f = f; o.ro = ro;
        o.w = 2'(w); o.w1 = 2'(w1); o.w2 = 2'(w2); o.mo = mo;
        return o;
    endfunction

    task automatic expect_out(input string nm, input out_t o);
        exp_q.push_back(o);
        name_q.push_back(nm);
    endtask

    // Drive one cycle of inputs, let the edge happen, then return to quiet inputs.
    task automatic step(input bit rst, input bit rs, input bit tk,
                        input bit h1, input int d1, input bit h2, input int d2);
        reset = rst; round_start = rs; tick = tk;
        hit1_lands = h1; dmg1 = 3'(d1); hit2_lands = h2; dmg2 = 3'(d2);
        @(posedge clk);
        #1;
        reset = 0; round_start = 0; tick = 0;
        hit1_lands = 0; hit2_lands = 0; dmg1 = 0; dmg2 = 0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                out_t  e, a;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {health1, health2, invuln1, invuln2, fighting, round_over,
                      winner, wins1, wins2, match_over};
                checks++;
                if (a === e) passes++;
                else $display("FAIL %s: got h1=%0d h2=%0d i=%b%b f=%b ro=%b w=%b w1=%0d w2=%0d mo=%b, want h1=%0d h2=%0d i=%b%b f=%b ro=%b w=%b w1=%0d w2=%0d mo=%b",
                              nm, a.h1, a.h2, a.i1, a.i2, a.f, a.ro, a.w, a.w1, a.w2, a.mo,
                              e.h1, e.h2, e.i1, e.i2, e.f, e.ro, e.w, e.w1, e.w2, e.mo);
            end
        end
    end

    initial begin
        reset = 1; tick = 0; round_start = 0; hit1_lands = 0; hit2_lands = 0; dmg1 = 0; dmg2 = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 5, 1, 5);
        expect_out("reset", mk(10, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, 0, 0);
        expect_out("start_r1", mk(10, 10, 0, 0, 1, 0, 0, 0, 0, 0));

        // Round 1: P1 wins through hits of 3, then 4 (ignored while invulnerable), 4, 4 (saturates).
        step(0, 0, 0, 1, 3, 0, 0);
        expect_out("t1_hit", mk(10, 7, 0, 1, 1, 0, 0, 0, 0, 0));
        ticks(25);
        step(0, 0, 0, 1, 4, 0, 0);
        expect_out("t3_ignored", mk(10, 7, 0, 1, 1, 0, 0, 0, 0, 0));
        ticks(4);
        expect_out("t3_still_invuln", mk(10, 7, 0, 1, 1, 0, 0, 0, 0, 0));
        ticks(1);
        expect_out("t3_expired", mk(10, 7, 0, 0, 1, 0, 0, 0, 0, 0));
        step(0, 0, 1, 1, 4, 0, 0);
        expect_out("hit_load_beats_tick", mk(10, 3, 0, 1, 1, 0, 0, 0, 0, 0));
        ticks(30);
        step(0, 0, 0, 1, 4, 0, 0);
        expect_out("ko_p2_saturate", mk(10, 0, 0, 1, 0, 1, 1, 1, 0, 0));

        // Round 2: simultaneous hits, zero damage, round_start ignored in FIGHT, draw.
        step(0, 1, 0, 0, 0, 0, 0);
        expect_out("start_r2", mk(10, 10, 0, 0, 1, 0, 0, 1, 0, 0));
        step(0, 0, 0, 1, 7, 1, 7);
        expect_out("both_hit", mk(3, 3, 1, 1, 1, 0, 0, 1, 0, 0));
        ticks(30);
        step(0, 0, 0, 1, 0, 0, 0);
        expect_out("dmg_zero", mk(3, 3, 0, 1, 1, 0, 0, 1, 0, 0));
        ticks(30);
        step(0, 1, 0, 1, 1, 1, 1);
        expect_out("start_during_hit", mk(2, 2, 1, 1, 1, 0, 0, 1, 0, 0));
        ticks(30);
        step(0, 0, 0, 1, 7, 1, 7);
        expect_out("t4_draw", mk(0, 0, 1, 1, 0, 1, 3, 1, 0, 0));
        step(0, 0, 0, 1, 7, 1, 7);
        expect_out("ko_hold_ignore", mk(0, 0, 1, 1, 0, 1, 3, 1, 0, 0));
        ticks(30);
        expect_out("ko_hold_decay", mk(0, 0, 0, 0, 0, 1, 3, 1, 0, 0));

        // Rounds 3 and 4: P2 takes two rounds and the match.
        step(0, 1, 0, 0, 0, 0, 0);
        expect_out("start_r3", mk(10, 10, 0, 0, 1, 0, 0, 1, 0, 0));
        step(0, 0, 0, 0, 0, 1, 7);
        expect_out("r3_hit", mk(3, 10, 1, 0, 1, 0, 0, 1, 0, 0));
        ticks(30);
        step(0, 0, 0, 0, 0, 1, 7);
        expect_out("r3_ko_p1", mk(0, 10, 1, 0, 0, 1, 2, 1, 1, 0));
        step(0, 1, 1, 0, 0, 0, 0);
        expect_out("start_r4", mk(10, 10, 0, 0, 1, 0, 0, 1, 1, 0));
        step(0, 0, 0, 0, 0, 1, 7);
        ticks(30);
        step(0, 0, 0, 0, 0, 1, 7);
        expect_out("t5_match_end", mk(0, 10, 1, 0, 0, 0, 2, 1, 2, 1));
        step(0, 1, 0, 1, 7, 1, 7);
        expect_out("t5_sticky", mk(0, 10, 1, 0, 0, 0, 2, 1, 2, 1));
        step(1, 1, 0, 0, 0, 0, 0);
        expect_out("t5_reset", mk(10, 10, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset mid-fight wins over a simultaneous hit.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7);
        expect_out("t6_pre", mk(3, 10, 1, 0, 1, 0, 0, 0, 0, 0));
        step(1, 0, 1, 1, 7, 1, 7);
        expect_out("t6_reset", mk(10, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 1, 1, 3, 1, 3);
        expect_out("idle_ignores_hits", mk(10, 10, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
            checks++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
